// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues a one-cycle dmem request, stalls until
// the response, then aligns/extends load data into the MEM/WB register.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    alu_out_wb,
    br_en_wb,
    u_imm_wb,
    pc_plus4_wb,
    lb_wb,
    lbu_wb,
    lh_wb,
    lhu_wb,
    lw_wb
  } regf_m_sel_t;

  typedef struct packed {
    logic        regf_we;
    regf_m_sel_t regf_m_sel;
  } wb_signal_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] u_imm;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    wb_signal_t  wb_signal;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [31:0] alu_out;
    logic        br_en;
    logic [31:0] u_imm;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    wb_signal_t  wb_signal;
  } mem_wb_stage_reg_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  ex_mem_stage_reg_t ex_mem_i,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              mem_stall,
  output mem_wb_stage_reg_t mem_wb_o,
  output logic [31:0]       mem_wb_rdata_o,
  output logic [31:0]       mem_wb_load_o,
  output logic [31:0]       mem_fwd_data,
  output logic              mem_fwd_ok,
  output logic              mem_timeout
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        access;
  logic        is_load;
  logic [31:0] wd_cnt;
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] load_val;
  regf_m_sel_t sel;

  assign sel = ex_mem_i.wb_signal.regf_m_sel;

  assign access = ex_mem_i.valid &&
                  ((ex_mem_i.mem_rmask | ex_mem_i.mem_wmask) != 4'b0);

  assign is_load = sel inside {lb_wb, lbu_wb, lh_wb, lhu_wb, lw_wb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (access) state_nxt = WAIT;
      WAIT: if (dmem_resp) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_addr   = 32'b0;
    dmem_rmask  = 4'b0;
    dmem_wmask  = 4'b0;
    dmem_wdata  = 32'b0;
    mem_stall   = 1'b0;
    mem_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          dmem_addr  = {ex_mem_i.mem_addr[31:2], 2'b00};
          dmem_rmask = ex_mem_i.mem_rmask;
          dmem_wmask = ex_mem_i.mem_wmask;
          dmem_wdata = ex_mem_i.mem_wdata;
          mem_stall  = 1'b1;
        end
      end
      WAIT: begin
        mem_stall   = !dmem_resp;
        mem_timeout = (WATCHDOG_CYCLES != 0) && !dmem_resp &&
                      (wd_cnt == WATCHDOG_CYCLES - 1);
      end
    endcase
  end

  // Saturates at the limit so the timeout pulses only once per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= 32'b0;
    end else if (state != WAIT || dmem_resp) begin
      wd_cnt <= 32'b0;
    end else if (WATCHDOG_CYCLES != 0 && wd_cnt < WATCHDOG_CYCLES) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign sh      = {ex_mem_i.mem_addr[1:0], 3'b000};
  assign shifted = dmem_rdata >> sh;

  always_comb begin
    load_val = 32'b0;
    unique case (sel)
      lb_wb:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      lbu_wb:  load_val = {24'b0, shifted[7:0]};
      lh_wb:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      lhu_wb:  load_val = {16'b0, shifted[15:0]};
      lw_wb:   load_val = dmem_rdata;
      default: load_val = 32'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_o       <= '0;
      mem_wb_rdata_o <= 32'b0;
      mem_wb_load_o  <= 32'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            mem_wb_o.valid <= 1'b0;
          end else begin
            mem_wb_o       <= ex_mem_i;
            mem_wb_rdata_o <= 32'b0;
            mem_wb_load_o  <= 32'b0;
          end
        end
        WAIT: begin
          if (dmem_resp) begin
            mem_wb_o       <= ex_mem_i;
            mem_wb_rdata_o <= dmem_rdata;
            mem_wb_load_o  <= load_val;
          end else begin
            mem_wb_o.valid <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_fwd_data = 32'b0;
    unique case (sel)
      alu_out_wb:  mem_fwd_data = ex_mem_i.alu_out;
      br_en_wb:    mem_fwd_data = {31'b0, ex_mem_i.br_en};
      u_imm_wb:    mem_fwd_data = ex_mem_i.u_imm;
      pc_plus4_wb: mem_fwd_data = ex_mem_i.pc + 32'd4;
      default:     mem_fwd_data = 32'b0;
    endcase
  end

  assign mem_fwd_ok = ex_mem_i.valid && ex_mem_i.wb_signal.regf_we &&
                      !is_load && (ex_mem_i.rd_s != 5'd0);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expected commits,
// a negedge monitor pops and compares each MEM/WB commit.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk;
  logic              rst_n;
  ex_mem_stage_reg_t ex_mem;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              mem_stall;
  mem_wb_stage_reg_t mem_wb;
  logic [31:0]       wb_rdata;
  logic [31:0]       wb_load;
  logic [31:0]       fwd_data;
  logic              fwd_ok;
  logic              timeout;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] load;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  mem_stage #(.WATCHDOG_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_mem_i      (ex_mem),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .mem_stall     (mem_stall),
    .mem_wb_o      (mem_wb),
    .mem_wb_rdata_o(wb_rdata),
    .mem_wb_load_o (wb_load),
    .mem_fwd_data  (fwd_data),
    .mem_fwd_ok    (fwd_ok),
    .mem_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic ex_mem_stage_reg_t mk(
    input regf_m_sel_t sel, input logic [31:0] addr,
    input logic [3:0] rm, input logic [3:0] wm,
    input logic [31:0] wd, input logic [31:0] alu,
    input logic [4:0] rd);
    ex_mem_stage_reg_t t;
    t = '0;
    t.valid = 1'b1;
    t.pc = 32'h0000_0100;
    t.inst = 32'h0000_0013;
    t.rd_s = rd;
    t.alu_out = alu;
    t.br_en = 1'b1;
    t.u_imm = 32'h1234_5000;
    t.mem_addr = addr;
    t.mem_rmask = rm;
    t.mem_wmask = wm;
    t.mem_wdata = wd;
    t.wb_signal.regf_we = (wm == 4'b0);
    t.wb_signal.regf_m_sel = sel;
    return t;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mem_wb.valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_commit: got alu 0x%08h expected none",
                 mem_wb.alu_out);
      end else begin
        e = q.pop_front();
        chk("wb_alu", mem_wb.alu_out, e.alu);
        chk("wb_rd", {27'b0, mem_wb.rd_s}, {27'b0, e.rd});
        chk("wb_rdata", wb_rdata, e.rdata);
        chk("wb_load", wb_load, e.load);
      end
    end
  end

  task automatic alu_op(input ex_mem_stage_reg_t ins,
                        input logic [31:0] exp_fwd, input logic exp_ok);
    exp_t e;
    @(posedge clk); #1;
    ex_mem = ins;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("alu_stall", {31'b0, mem_stall}, 32'd0);
    chk("alu_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'd0);
    chk("fwd_data", fwd_data, exp_fwd);
    chk("fwd_ok", {31'b0, fwd_ok}, {31'b0, exp_ok});
    e.alu = ins.alu_out;
    e.rdata = 32'b0;
    e.load = 32'b0;
    e.rd = ins.rd_s;
    q.push_back(e);
  endtask

  task automatic access(input ex_mem_stage_reg_t ins, input int dly,
                        input logic [31:0] rd, input logic [31:0] exp_load);
    exp_t e;
    @(posedge clk); #1;
    ex_mem = ins;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("req_stall", {31'b0, mem_stall}, 32'd1);
    chk("req_addr", dmem_addr, {ins.mem_addr[31:2], 2'b00});
    chk("req_rmask", {28'b0, dmem_rmask}, {28'b0, ins.mem_rmask});
    chk("req_wmask", {28'b0, dmem_wmask}, {28'b0, ins.mem_wmask});
    chk("req_wdata", dmem_wdata, ins.mem_wdata);
    chk("req_fwd_ok", {31'b0, fwd_ok}, 32'd0);
    e.alu = ins.alu_out;
    e.rdata = rd;
    e.load = exp_load;
    e.rd = ins.rd_s;
    q.push_back(e);
    for (int k = 1; k <= dly; k++) begin
      @(posedge clk); #1;
      if (k == dly) begin
        dmem_resp = 1'b1;
        dmem_rdata = rd;
      end
      @(negedge clk);
      chk("wait_stall", {31'b0, mem_stall}, {31'b0, k != dly});
      chk("wait_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'd0);
      chk("wait_timeout", {31'b0, timeout},
          {31'b0, (k == 4) && (k != dly)});
    end
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    dmem_rdata = 32'hDEAD_0000;
    ex_mem = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_mem = '0;
    dmem_resp = 1'b0;
    dmem_rdata = 32'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, mem_wb.valid}, 32'd0);
    chk("rst_rdata", wb_rdata, 32'd0);
    chk("rst_load", wb_load, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    alu_op(mk(alu_out_wb, 0, 0, 0, 0, 32'h1234, 5'd5), 32'h1234, 1'b1);
    alu_op(mk(br_en_wb, 0, 0, 0, 0, 32'h0A, 5'd0), 32'h1, 1'b0);
    alu_op(mk(u_imm_wb, 0, 0, 0, 0, 32'h0B, 5'd7), 32'h1234_5000, 1'b1);
    alu_op(mk(pc_plus4_wb, 0, 0, 0, 0, 32'h0C, 5'd8), 32'h104, 1'b1);

    access(mk(lb_wb, 32'h1003, 4'b1000, 0, 0, 32'h1003, 5'd9),
           1, 32'h80AA_BBCC, 32'hFFFF_FF80);
    access(mk(lbu_wb, 32'h1001, 4'b0010, 0, 0, 32'h1001, 5'd10),
           1, 32'h80AA_BBCC, 32'h0000_00BB);
    access(mk(lhu_wb, 32'h2002, 4'b1100, 0, 0, 32'h2002, 5'd11),
           1, 32'hBEEF_1234, 32'h0000_BEEF);
    access(mk(lh_wb, 32'h2002, 4'b1100, 0, 0, 32'h2002, 5'd12),
           2, 32'hBEEF_1234, 32'hFFFF_BEEF);
    access(mk(lw_wb, 32'h2004, 4'hF, 0, 0, 32'h2004, 5'd13),
           1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    access(mk(alu_out_wb, 32'h3000, 0, 4'hF, 32'hDEAD_BEEF, 32'h3000,
              5'd0), 3, 32'h0000_0055, 32'h0);
    access(mk(lw_wb, 32'h4008, 4'hF, 0, 0, 32'h4008, 5'd14),
           7, 32'h1357_9BDF, 32'h1357_9BDF);

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    ex_mem = mk(lw_wb, 32'h5000, 4'hF, 0, 0, 32'h5000, 5'd15);
    @(negedge clk);
    chk("rw_req_stall", {31'b0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wait_stall", {31'b0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    ex_mem = '0;
    #1;
    chk("rw_rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rw_rst_valid", {31'b0, mem_wb.valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("stray_stall", {31'b0, mem_stall}, 32'd0);
    chk("stray_masks", {24'b0, dmem_rmask, dmem_wmask}, 32'd0);
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_valid", {31'b0, mem_wb.valid}, 32'd0);

    access(mk(lbu_wb, 32'h6002, 4'b0100, 0, 0, 32'h6002, 5'd16),
           1, 32'h0077_0000, 32'h0000_0077);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM and MEM/WB stage registers.
- Consumes the EX/MEM bundle and issues a single-pulse request on the data-memory port.
- Stalls the pipeline until `dmem_resp` arrives, then aligns and extends load data and registers the MEM/WB bundle for writeback.
- Also supplies the MEM-stage forwarding value to EX.

Parameters:
- WATCHDOG_CYCLES, 0, cycles spent in WAIT before `mem_timeout` pulses; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_mem_i  in  ex_mem_stage_reg_t  current EX/MEM register contents
- dmem_addr  out  32  word-aligned address ({mem_addr[31:2],2'b00})
- dmem_rmask  out  4  read byte mask
- dmem_wmask  out  4  write byte mask
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  read data, valid with `dmem_resp`
- dmem_resp  in  1  memory response, one-cycle pulse
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register
- mem_wb_o  out  mem_wb_stage_reg_t  registered MEM/WB bundle
- mem_wb_rdata_o  out  32  registered raw dmem_rdata (RVFI)
- mem_wb_load_o  out  32  registered aligned, extended load value
- mem_fwd_data  out  32  combinational forwarding value of ex_mem_i
- mem_fwd_ok  out  1  ex_mem_i is valid, regf_we=1, not a load, rd_s!=0
- mem_timeout  out  1  watchdog pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; watchdog counter=0.
  - mem_wb_o, mem_wb_rdata_o and mem_wb_load_o are all zero, so mem_wb_o.valid=0.
  - All dmem masks=0; mem_stall=0; mem_timeout=0.
- An access exists when ex_mem_i.valid=1 and (mem_rmask|mem_wmask)!=0.
- IDLE:
  - With an access present: drive dmem_addr/rmask/wmask/wdata from ex_mem_i combinationally this cycle, assert mem_stall, next state WAIT.
  - Non-access valid instruction: mem_stall=0; at the edge mem_wb_o<=ex_mem_i, and both rdata outputs <=0.
  - Bubble (valid=0): mem_wb_o.valid<=0 at the edge.
  - dmem_resp in IDLE is ignored; this covers stray responses after reset.
- WAIT:
  - dmem masks=0; the request is exactly a one-cycle pulse.
  - mem_stall=1 while dmem_resp=0; mem_wb_o.valid<=0 each stalled edge, so no duplicate commit.
  - Cycle with dmem_resp=1: mem_stall=0.
    - At the edge: mem_wb_o<=ex_mem_i, mem_wb_rdata_o<=dmem_rdata, mem_wb_load_o<=extracted value, state<=IDLE.
    - Upstream advances on the same edge.
- Minimum access latency: request cycle + 1 response cycle = 2 cycles of EX/MEM occupancy; 1 stall cycle.
- Load extraction, with sh = mem_addr[1:0]*8 and r = dmem_rdata>>sh:
  - lb: sign-extend r[7:0]. lbu: zero-extend r[7:0].
  - lh: sign-extend r[15:0]. lhu: zero-extend r[15:0].
  - lw: dmem_rdata.
  - Stores and other encodings: 0.
- Forwarding, selected by wb_signal.regf_m_sel:
  - alu_out_wb→alu_out
  - br_en_wb→br_en
  - u_imm_wb→u_imm
  - pc_plus4_wb→pc+4
  - load selects→0, with mem_fwd_ok=0
- Watchdog (WATCHDOG_CYCLES>0):
  - Counter increments each WAIT cycle without resp and clears on leaving WAIT.
  - mem_timeout=1 for exactly one cycle when the counter reaches WATCHDOG_CYCLES.
  - State stays WAIT.
- Simultaneous events:
  - rmask and wmask both nonzero are issued as given.
  - No new request can issue in the resp cycle; the next access issues in IDLE on the following cycle.
- Reset mid-WAIT: the outstanding request is abandoned, state=IDLE, no output valid.

Test Plan:
- ALU op, valid, regf_m_sel=alu_out_wb, alu_out=0x1234 → mem_stall=0, dmem masks=0, mem_fwd_data=0x1234, mem_fwd_ok=1; next cycle mem_wb_o.valid=1, mem_wb_o.alu_out=0x1234.
- lb at mem_addr=0x1003, rmask=4'b1000, resp after 1 cycle with rdata=0x80AABBCC → dmem_addr=0x1000 for one cycle, mem_stall=1 for 1 cycle, mem_wb_load_o=0xFFFFFF80, mem_wb_rdata_o=0x80AABBCC.
- lhu at mem_addr=0x2002, rdata=0xBEEF1234 → mem_wb_load_o=0x0000BEEF; the same access with lh → 0xFFFFBEEF.
- sw with wmask=4'hF, wdata=0xDEADBEEF, resp 3 cycles after request → wmask nonzero exactly 1 cycle; mem_stall high 3 cycles then low in the resp cycle; exactly one mem_wb_o.valid=1 cycle.
- WATCHDOG_CYCLES=4, no resp → mem_timeout pulses once on the 4th WAIT cycle and mem_stall stays 1; a later resp completes normally.
- rst_n low during WAIT, then a stray dmem_resp in IDLE → mem_wb_o.valid=0, no stall, response ignored; the next load issues normally.
